// File: rtl/gate_result_fifo.sv
// gate_result_fifo: change-detecting sampler of {X,Y,Z} feeding a first-word-fall-through FIFO
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   en            : sampling enable
//   X, Y, Z       : gate outputs sampled as one entry {X,Y,Z}
//   pop           : consumer removes the head entry
//   DX, DY, DZ    : head entry fields, zero when empty
//   valid, full   : not empty / holding DEPTH entries
//   count         : number of stored entries
//   drop_cnt      : saturating count of changed samples lost to a full FIFO
module gate_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           X,
  input  logic [WIDTH-1:0]           Y,
  input  logic [WIDTH-1:0]           Z,
  input  logic                       pop,
  output logic [WIDTH-1:0]           DX,
  output logic [WIDTH-1:0]           DY,
  output logic [WIDTH-1:0]           DZ,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = 3 * WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] sample, last, head;
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          have_last, chg, do_pop, do_push, drop;
  assign sample  = {X, Y, Z};
  assign chg     = en && (!have_last || sample != last);
  assign do_pop  = pop && cnt != '0;
  // a full FIFO still accepts a change when the head leaves in the same cycle
  assign do_push = chg && (cnt != FULL_CNT || do_pop);
  assign drop    = chg && cnt == FULL_CNT && !do_pop;
  assign head    = cnt != '0 ? mem[rp] : '0;
  assign {DX, DY, DZ} = head;
  assign valid   = cnt != '0;
  assign full    = cnt == FULL_CNT;
  assign count   = cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      last      <= '0;
      have_last <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (chg) begin
        last      <= sample;
        have_last <= 1'b1;
      end
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= do_push && !do_pop ? cnt + 1'b1 : !do_push && do_pop ? cnt - 1'b1 : cnt;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= sample;
endmodule

// File: tb/tb_gate_result_fifo.sv
// tb_gate_result_fifo: scoreboard bench for gate_result_fifo with directed vectors
module tb_gate_result_fifo;
  logic       clk = 0, rst = 1, en = 0, pop = 0;
  logic [3:0] X = 0, Y = 0, Z = 0;
  logic [3:0] DX, DY, DZ;
  logic       valid, full;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  logic [11:0] q[$];

  gate_result_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .X(X), .Y(Y), .Z(Z), .pop(pop),
    .DX(DX), .DY(DY), .DZ(DZ), .valid(valid), .full(full),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: whenever an entry leaves, it must match the oldest expected entry
  always @(negedge clk)
    if (!rst && valid && pop) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h want none", {DX, DY, DZ});
      end else begin
        logic [11:0] e;
        e = q.pop_front();
        if ({DX, DY, DZ} !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h want %0h", {DX, DY, DZ}, e);
        end
      end
    end

  // one cycle of stimulus; exp_push records the hand-computed push decision
  task automatic step(input logic e, input logic [3:0] x, input logic [3:0] y,
                      input logic [3:0] z, input logic p, input logic exp_push);
    en = e; X = x; Y = y; Z = z; pop = p;
    if (exp_push) q.push_back({x, y, z});
    @(posedge clk);
    #1;
    en = 0; pop = 0;
  endtask

  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_valid", valid, 0);
    chk("rst_full", full, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_head", {DX, DY, DZ}, 0);
    @(posedge clk); #1; rst = 0;
    // constant zero sample: only the first cycle pushes
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    chk("hold_count", count, 1);
    chk("hold_valid", valid, 1);
    chk("hold_head", {DX, DY, DZ}, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("hold_drain", count, 0);
    // ordered traffic
    step(1, 4'hF, 4'hA, 4'h0, 0, 1);
    step(1, 4'hB, 4'h8, 4'h1, 0, 1);
    step(1, 4'h5, 4'h8, 4'hA, 0, 1);
    chk("three_count", count, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    chk("three_empty", count, 0);
    chk("three_head0", {DX, DY, DZ}, 0);
    chk("three_valid", valid, 0);
    // overflow: six distinct samples into four slots
    for (int i = 1; i <= 6; i++) step(1, 4'(i), 4'(i), 4'(i), 0, i <= 4);
    chk("ovf_count", count, 4);
    chk("ovf_full", full, 1);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_head", {DX, DY, DZ}, 12'h111);
    // full with simultaneous push and pop
    step(1, 7, 7, 7, 1, 1);
    chk("fpp_count", count, 4);
    chk("fpp_head", {DX, DY, DZ}, 12'h222);
    chk("fpp_drop", drop_cnt, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    chk("fpp_drain", count, 0);
    // pop while empty together with a new sample
    step(1, 8, 8, 8, 1, 1);
    chk("epop_count", count, 1);
    chk("epop_head", {DX, DY, DZ}, 12'h888);
    step(0, 0, 0, 0, 1, 0);
    chk("epop_drain", count, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("epop_under", count, 0);
    // asynchronous reset mid-operation
    step(1, 9, 9, 9, 0, 1);
    step(1, 4'hA, 4'hA, 4'hA, 0, 1);
    step(1, 4'hB, 4'hB, 4'hB, 0, 1);
    chk("ar_pre", count, 3);
    #2 rst = 1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", valid, 0);
    chk("ar_head", {DX, DY, DZ}, 0);
    q.delete();
    rst = 0;
    step(1, 4'hB, 4'hB, 4'hB, 0, 1);
    chk("ar_repush", count, 1);
    chk("ar_rehead", {DX, DY, DZ}, 12'hBBB);
    step(0, 0, 0, 0, 1, 0);
    // saturation: 4 pushes then 300 drops
    for (int i = 0; i < 304; i++) begin
      logic [11:0] v;
      v = 12'(i);
      step(1, v[3:0], v[7:4], v[11:8], 0, i < 4);
    end
    chk("sat_drop", drop_cnt, 255);
    chk("sat_count", count, 4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    chk("sat_drain", count, 0);
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gate_result_fifo.md
GATE_RESULT_FIFO -- requirements
Module: gate_result_fifo

Interface
REQ-001 Parameter WIDTH, default 4, width of each of X, Y, Z and DX, DY, DZ.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  sampling enable.
- X  in  WIDTH  gate output X from test_gate.
- Y  in  WIDTH  gate output Y from test_gate.
- Z  in  WIDTH  gate output Z from test_gate.
- pop  in  1  consumer removes the head entry.
- DX  out  WIDTH  head entry, X field.
- DY  out  WIDTH  head entry, Y field.
- DZ  out  WIDTH  head entry, Z field.
- valid  out  1  FIFO not empty.
- full  out  1  count equals DEPTH.
- count  out  clog2(DEPTH)+1  number of stored entries.
- drop_cnt  out  8  saturating count of dropped samples.

Function
REQ-005 Sample S SHALL be {X,Y,Z}, which is 3*WIDTH bits, taken at the rising clk edge.
REQ-006 A change event SHALL occur when en=1 and either have_last=0 or S differs from the last-sample register L.
REQ-007 On every change event, L SHALL load S and have_last SHALL be set to 1, whether or not the sample is stored.
REQ-008 When en=0, no change event SHALL occur, and L and have_last SHALL hold.
REQ-009 An unchanged sample with en=1 SHALL NOT push.
REQ-010 A change event SHALL push S at the write pointer when count<DEPTH, or when count=DEPTH and an effective pop occurs in the same cycle.
REQ-011 A change event with count=DEPTH and no pop SHALL drop S, and drop_cnt SHALL increment, saturating at 255.
REQ-012 An effective pop SHALL occur when pop=1 and count>0; pop while count=0 SHALL be ignored with no error.
REQ-013 Push and pop in the same cycle when 0<count<DEPTH SHALL leave count unchanged.
REQ-014 Push and pop in the same cycle when count=0 SHALL push only, giving count=1.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH.
REQ-016 The FIFO SHALL be first-word-fall-through: DX, DY and DZ SHALL show the head entry combinationally from storage whenever count>0.
REQ-017 DX, DY and DZ SHALL be all zeros when count=0.
REQ-018 valid SHALL equal (count!=0) and full SHALL equal (count==DEPTH); both SHALL be combinational from count.
REQ-019 A pushed entry SHALL be visible on DX, DY and DZ, with valid=1, in the cycle after its sampling edge, which is 1-cycle latency.
REQ-020 Entries SHALL leave the FIFO strictly in push order.

Reset
REQ-021 rst=1 SHALL immediately, without waiting for clk, clear count, pointers, have_last, L and drop_cnt.
REQ-022 While rst=1, outputs SHALL read DX=DY=DZ=0, valid=0, full=0, count=0, drop_cnt=0.
REQ-023 Storage array contents need not be cleared by reset.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries.
REQ-025 The first change event after reset release SHALL always push, because have_last=0.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Reset, then en=1 with X=Y=Z=0 held for 5 cycles -> exactly 1 push; count=1; DX=DY=DZ=0; valid=1.
- Samples {F,A,0}, {B,8,1}, {5,8,A}, one per cycle, from an empty FIFO, then pop each cycle -> DX/DY/DZ read F/A/0, then B/8/1, then 5/8/A; count ends at 0 and DX=DY=DZ=0.
- Six distinct samples, no pop, DEPTH=4 -> count=4; full=1; drop_cnt=2; head is the first sample.
- FIFO full, with a distinct sample and pop=1 in the same cycle -> count stays 4; head advances to the 2nd entry; drop_cnt unchanged.
- pop=1 while empty, together with a new sample -> count=1; no underflow; pointers consistent on the next pop.
- Asynchronous rst pulse between clk edges while count=3 -> count=0 and valid=0 before the next edge; the next sample pushes even if it equals the pre-reset L.
- 300 drops -> drop_cnt=255.
